// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter for a 16x8 single-port asynchronous RAM.
// Each transaction takes three cycles: grant, RAM access, done.
// Every output comes from a register. Request fields are captured on the grant edge.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  mem_we,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_r, next_state_s;
    logic                    owner_r, owner_s;
    logic                    we_r;
    logic                    last_r;
    logic                    grant_s, rd_load_s, busy_s;
    logic                    gnt0_s, gnt1_s, done0_s, done1_s, mem_we_s, mem_en_s;
    logic                    gnt0_r, gnt1_r, done0_r, done1_r, mem_we_r, mem_en_r, busy_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r, rdata0_r, rdata1_r;

    // Next-state and next-output decode. Outputs are one cycle ahead of their registers.
    always_comb begin
        next_state_s = state_r;
        owner_s      = owner_r;
        grant_s      = 1'b0;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        done0_s      = 1'b0;
        done1_s      = 1'b0;
        mem_we_s     = 1'b0;
        mem_en_s     = 1'b0;
        rd_load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // last_r == 1 means client 1 went last, so client 0 wins a tie
                if (req0 && (!req1 || last_r)) begin
                    grant_s      = 1'b1;
                    owner_s      = 1'b0;
                    gnt0_s       = 1'b1;
                    next_state_s = ACCESS;
                end else if (req1) begin
                    grant_s      = 1'b1;
                    owner_s      = 1'b1;
                    gnt1_s       = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                mem_we_s     = we_r;
                mem_en_s     = ~we_r;
                next_state_s = DONE;
            end
            DONE: begin
                done0_s      = ~owner_r;
                done1_s      = owner_r;
                rd_load_s    = ~we_r;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        busy_s = (next_state_s != IDLE);
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the granted client's request fields. mem_addr/mem_wdata then hold until the next grant.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (grant_s) begin
            owner_r     <= owner_s;
            we_r        <= owner_s ? we1 : we0;
            mem_addr_r  <= owner_s ? addr1 : addr0;
            mem_wdata_r <= owner_s ? wdata1 : wdata0;
        end
    end

    // Registered pulses and RAM controls. Reset clears mem_we/mem_en at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
            mem_we_r <= 1'b0;
            mem_en_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            gnt0_r   <= gnt0_s;
            gnt1_r   <= gnt1_s;
            done0_r  <= done0_s;
            done1_r  <= done1_s;
            mem_we_r <= mem_we_s;
            mem_en_r <= mem_en_s;
            busy_r   <= busy_s;
        end
    end

    // Round-robin memory. It starts at client 1, so client 0 wins the first tie.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_r <= 1'b1;
        end else if (state_r == DONE) begin
            last_r <= owner_r;
        end
    end

    // Per-client read result. It holds until that client's next read completes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata0_r <= {DATA_WIDTH{1'b0}};
            rdata1_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_load_s) begin
            if (owner_r) begin
                rdata1_r <= mem_rdata;
            end else begin
                rdata0_r <= mem_rdata;
            end
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign done0     = done0_r;
    assign done1     = done1_r;
    assign busy      = busy_r;
    assign mem_we    = mem_we_r;
    assign mem_en    = mem_en_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter.
// A behavioural 16x8 RAM model is attached to the arbiter.
// Per-client scoreboard queues hold the expected RAM access and read data for each grant.
module tb_ram_arbiter;

    logic       clock;
    logic       resetn;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, busy, mem_we, mem_en;
    logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [3:0] mem_addr;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } op_t;

    typedef struct {
        logic       c;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    op_t  q0[$];
    op_t  q1[$];
    bit   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gcyc0 = 0;
    int   gcyc1 = 0;
    op_t  mem_exp;
    bit   mem_exp_v = 1'b0;
    logic [7:0] model0, model1;

    logic [7:0] ram [16];
    logic       ram_init = 1'b0;

    ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_we(mem_we), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: combinational read, write when mem_we is high at a clock edge
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
            ram[15]  <= 8'hF0;
            ram_init <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor: exclusivity rules, RAM access after each grant, and done/rdata scoreboard
    initial begin
        op_t o;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                mem_exp_v = 1'b0;
            end else begin
                chk("mem_we_and_en", {31'd0, mem_we & mem_en}, 32'd0);
                chk("gnt_both", {31'd0, gnt0 & gnt1}, 32'd0);
                chk("done_both", {31'd0, done0 & done1}, 32'd0);
                if (mem_exp_v) begin
                    mem_exp_v = 1'b0;
                    chk("access_mem_we", {31'd0, mem_we}, {31'd0, mem_exp.we});
                    chk("access_mem_en", {31'd0, mem_en}, {31'd0, ~mem_exp.we});
                    chk("access_mem_addr", {28'd0, mem_addr}, {28'd0, mem_exp.addr});
                    if (mem_exp.we) chk("access_mem_wdata", {24'd0, mem_wdata}, {24'd0, mem_exp.wdata});
                end
                if (gnt0) begin
                    glog.push_back(1'b0);
                    gcyc0 = cyc;
                    if (q0.size() == 0) chk("unexpected_gnt0", 32'd1, 32'd0);
                    else begin mem_exp = q0[0]; mem_exp_v = 1'b1; end
                end
                if (gnt1) begin
                    glog.push_back(1'b1);
                    gcyc1 = cyc;
                    if (q1.size() == 0) chk("unexpected_gnt1", 32'd1, 32'd0);
                    else begin mem_exp = q1[0]; mem_exp_v = 1'b1; end
                end
                if (done0) begin
                    if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
                    else begin
                        o = q0.pop_front();
                        chk("gnt0_to_done0", cyc - gcyc0, 32'd2);
                        if (!o.we) chk("rdata0", {24'd0, rdata0}, {24'd0, o.rdata});
                    end
                end
                if (done1) begin
                    if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
                    else begin
                        o = q1.pop_front();
                        chk("gnt1_to_done1", cyc - gcyc1, 32'd2);
                        if (!o.we) chk("rdata1", {24'd0, rdata1}, {24'd0, o.rdata});
                    end
                end
            end
        end
    end

    task automatic push_op(input logic c, input logic we, input logic [3:0] a,
                           input logic [7:0] d, input logic [7:0] e);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d; o.rdata = e;
        if (c) q1.push_back(o);
        else   q0.push_back(o);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clock);
            if (q0.size() == 0 && q1.size() == 0 && !busy && !done0 && !done1) ok = 1'b1;
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
        chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
        chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
        chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, {28'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_rdata0"}, {24'd0, rdata0}, 32'd0);
        chk({tag, "_rdata1"}, {24'd0, rdata1}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        bit got = 1'b0;
        push_op(v.c, v.we, v.addr, v.wdata, v.exp);
        @(negedge clock);
        if (v.c) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        else     begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (v.c ? gnt1 : gnt0) got = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("gnt_timeout", {31'd0, got}, 32'd1);
        wait_idle();
    endtask

    // Both clients request together. Client 0 must win first, and client 1 follows 3 cycles later.
    task automatic sim_pair(input logic we, input logic [3:0] a0, input logic [7:0] d0, input logic [7:0] e0,
                            input logic [3:0] a1, input logic [7:0] d1, input logic [7:0] e1);
        int c0 = -1;
        int c1 = -1;
        push_op(1'b0, we, a0, d0, e0);
        push_op(1'b1, we, a1, d1, e1);
        @(negedge clock);
        req0 = 1'b1; we0 = we; addr0 = a0; wdata0 = d0;
        req1 = 1'b1; we1 = we; addr1 = a1; wdata1 = d1;
        for (int i = 0; i < 20 && (c0 < 0 || c1 < 0); i++) begin
            @(negedge clock);
            if (gnt0 && c0 < 0) begin c0 = cyc; req0 = 1'b0; end
            if (gnt1 && c1 < 0) begin c1 = cyc; req1 = 1'b0; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("pair_gnt0_seen", {31'd0, c0 >= 0}, 32'd1);
        chk("pair_gnt1_minus_gnt0", c1 - c0, 32'd3);
        wait_idle();
    endtask

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{c: 1'b0, we: 1'b0, addr: 4'h1, wdata: 8'h00, exp: 8'h11};
        vecs[1]  = '{c: 1'b1, we: 1'b0, addr: 4'h2, wdata: 8'h00, exp: 8'h22};
        vecs[2]  = '{c: 1'b0, we: 1'b1, addr: 4'h3, wdata: 8'hA5, exp: 8'h00};
        vecs[3]  = '{c: 1'b0, we: 1'b0, addr: 4'h3, wdata: 8'h00, exp: 8'hA5};
        vecs[4]  = '{c: 1'b1, we: 1'b0, addr: 4'hF, wdata: 8'h00, exp: 8'hF0};
        vecs[5]  = '{c: 1'b1, we: 1'b1, addr: 4'h7, wdata: 8'h3C, exp: 8'h00};
        vecs[6]  = '{c: 1'b0, we: 1'b0, addr: 4'h7, wdata: 8'h00, exp: 8'h3C};
        vecs[7]  = '{c: 1'b0, we: 1'b1, addr: 4'h0, wdata: 8'h5A, exp: 8'h00};
        vecs[8]  = '{c: 1'b1, we: 1'b0, addr: 4'h0, wdata: 8'h00, exp: 8'h5A};
        vecs[9]  = '{c: 1'b0, we: 1'b1, addr: 4'hF, wdata: 8'hFF, exp: 8'h00};
        vecs[10] = '{c: 1'b1, we: 1'b0, addr: 4'hF, wdata: 8'h00, exp: 8'hFF};

        resetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
        model0 = 8'h00; model1 = 8'h00;
        repeat (3) @(negedge clock);
        outputs_zero("reset");
        resetn = 1'b1;
        @(negedge clock);
        outputs_zero("after_reset");

        // Simultaneous writes straight out of reset
        sim_pair(1'b1, 4'h1, 8'h11, 8'h00, 4'h2, 8'h22, 8'h00);

        // Single-client vectors. After each one, both rdata ports must match the model.
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i]);
            if (!vecs[i].we) begin
                if (vecs[i].c) model1 = vecs[i].exp;
                else           model0 = vecs[i].exp;
            end
            chk($sformatf("vec%0d_rdata0_hold", i), {24'd0, rdata0}, {24'd0, model0});
            chk($sformatf("vec%0d_rdata1_hold", i), {24'd0, rdata1}, {24'd0, model1});
        end

        // Fairness: both clients hold reads for 12 cycles; client 1 was served last
        push_op(1'b0, 1'b0, 4'h1, 8'h00, 8'h11);
        push_op(1'b1, 1'b0, 4'h2, 8'h00, 8'h22);
        push_op(1'b0, 1'b0, 4'h1, 8'h00, 8'h11);
        push_op(1'b1, 1'b0, 4'h2, 8'h00, 8'h22);
        glog.delete();
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        repeat (12) @(negedge clock);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
        chk("fair_grant_count", glog.size(), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++)
            chk($sformatf("fair_grant%0d", i), {31'd0, glog[i]}, i % 2);
        model0 = 8'h11;
        model1 = 8'h22;

        // Reset while the RAM write is active
        push_op(1'b0, 1'b1, 4'h5, 8'h77, 8'h00);
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h5; wdata0 = 8'h77;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clock);
                if (gnt0) got = 1'b1;
            end
            chk("rst_gnt0_timeout", {31'd0, got}, 32'd1);
        end
        req0 = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_pre_mem_we", {31'd0, mem_we}, 32'd1);
        chk("rst_pre_mem_addr", {28'd0, mem_addr}, 32'd5);
        resetn = 1'b0;
        #1;
        outputs_zero("mid_reset");
        q0.delete();
        q1.delete();
        model0 = 8'h00;
        model1 = 8'h00;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        // Any done pulse here has no scoreboard entry and is reported by the monitor
        repeat (4) begin
            @(negedge clock);
            chk("post_reset_busy", {31'd0, busy}, 32'd0);
        end
        outputs_zero("post_reset");

        // Round-robin pointer is back at client 1, so client 0 wins again
        sim_pair(1'b0, 4'h1, 8'h00, 8'h11, 4'h2, 8'h00, 8'h22);
        chk("final_rdata0", {24'd0, rdata0}, 32'h11);
        chk("final_rdata1", {24'd0, rdata1}, 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
